// File: rtl/seq_sm_mul.sv
// Sequential sign-magnitude multiplier: shift-add, one multiplier bit per clock.
// Optional early completion when the remaining multiplier is zero: SEQ_SM_MUL_EARLY_EXIT_EN.
module seq_sm_mul #(
    parameter int MAG_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAG_W:0]     a,
    input  logic [MAG_W:0]     b,
    output logic               busy,
    output logic               done,
    output logic [2*MAG_W:0]   product
);

    localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [MAG_W-1:0]     mcand;
    logic [MAG_W-1:0]     mplier;
    logic [2*MAG_W-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 sign_q;

    logic [2*MAG_W-1:0]   addend;
    logic [2*MAG_W-1:0]   acc_sum;
    logic                 last_iter;
    logic                 accept;

    always_comb begin
        addend  = '0;
        if (mplier[0]) begin
            addend = {{MAG_W{1'b0}}, mcand} << cnt;
        end
        acc_sum = acc + addend;
        accept  = start && ((state == IDLE) || (state == DONE));
`ifdef SEQ_SM_MUL_EARLY_EXIT_EN
        last_iter = (cnt == CNT_W'(MAG_W - 1)) || ((mplier >> 1) == '0);
`else
        last_iter = (cnt == CNT_W'(MAG_W - 1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            sign_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    acc    <= acc_sum;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // A zero magnitude forces a positive sign, so -0 never appears.
                        product <= {sign_q && (acc_sum != '0), acc_sum};
                    end
                end
                IDLE, DONE: begin
                    if (accept) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        mcand  <= a[MAG_W-1:0];
                        mplier <= b[MAG_W-1:0];
                        acc    <= '0;
                        cnt    <= '0;
                        sign_q <= a[MAG_W] ^ b[MAG_W];
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
